// File: rtl/hpm_counter_bank.sv
// Bank of NumCounters generic HPM counters (mhpmcounter3..) with per-privilege
// filtering. Optional Sscofpmf-style overflow/interrupt: define HPM_OVERFLOW_IRQ_EN.

module hpm_counter_slice #(
  parameter int CounterWidth = 64,
  parameter int NumEvents    = 48,
  parameter int EventIdWidth = 8,
  parameter int IncWidth     = 4,
  parameter int XLEN         = 64
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               cnt_en_i,
  input  logic [1:0]                         priv_lvl_i,
  input  logic [NumEvents-1:0][IncWidth-1:0] lanes_i,
  input  logic                               cnt_wr_lo_i,
  input  logic                               cnt_wr_hi_i,
  input  logic                               evt_wr_lo_i,
  input  logic                               evt_wr_hi_i,
  input  logic [63:0]                        wdata_i,
  output logic [63:0]                        cnt_view_o,
  output logic [63:0]                        evt_view_o,
  output logic                               of_o
);
  localparam int SumW = CounterWidth + 1;

  typedef struct packed {
    logic                    of;
    logic                    minh;
    logic                    sinh;
    logic                    uinh;
    logic [EventIdWidth-1:0] sel;
  } evt_cfg_t;

  evt_cfg_t                cfg_q, cfg_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [IncWidth-1:0]     inc;
  logic [SumW-1:0]         sum;
  logic [63:0]             cnt_new;
  logic [3:0]              wflags;
  logic                    en, cnt_wr, wr_flags, ovf;

  always_comb begin
    inc = '0;
    for (int e = 0; e < NumEvents; e++)
      if (cfg_q.sel == EventIdWidth'(e)) inc = lanes_i[e];
    if (cfg_q.sel == '0) inc = '0;
  end

  assign en = cnt_en_i
           && !(cfg_q.minh && priv_lvl_i == 2'd3)
           && !(cfg_q.sinh && priv_lvl_i == 2'd1)
           && !(cfg_q.uinh && priv_lvl_i == 2'd0);
  assign sum    = {1'b0, cnt_q} + SumW'(inc);
  assign cnt_wr = cnt_wr_lo_i | cnt_wr_hi_i;
  // a software write to the counter masks this cycle's carry
  assign ovf    = en && !cnt_wr && sum[CounterWidth];

  assign cnt_view_o = 64'(cnt_q);

  always_comb begin
    evt_view_o        = 64'(cfg_q.sel);
    evt_view_o[63:60] = {cfg_q.of, cfg_q.minh, cfg_q.sinh, cfg_q.uinh};
  end

  // half writes keep the other half at its pre-increment value
  always_comb begin
    cnt_new = cnt_view_o;
    if (XLEN == 64) begin
      if (cnt_wr_lo_i) cnt_new = wdata_i;
    end else begin
      if (cnt_wr_lo_i) cnt_new[31:0]  = wdata_i[31:0];
      if (cnt_wr_hi_i) cnt_new[63:32] = wdata_i[31:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_wr)  cnt_d = cnt_new[CounterWidth-1:0];
    else if (en) cnt_d = sum[CounterWidth-1:0];
  end

  assign wflags   = (XLEN == 64) ? wdata_i[63:60] : wdata_i[31:28];
  assign wr_flags = (XLEN == 64) ? evt_wr_lo_i : evt_wr_hi_i;

  always_comb begin
    cfg_d = cfg_q;
    if (evt_wr_lo_i) cfg_d.sel = wdata_i[EventIdWidth-1:0];
    if (wr_flags) {cfg_d.of, cfg_d.minh, cfg_d.sinh, cfg_d.uinh} = wflags;
`ifdef HPM_OVERFLOW_IRQ_EN
    // hardware set wins over a concurrent software clear
    cfg_d.of = cfg_d.of | ovf;
`else
    cfg_d.of = 1'b0;
`endif
  end

`ifndef HPM_OVERFLOW_IRQ_EN
  logic unused_ovf;
  assign unused_ovf = ovf;
`endif

  assign of_o = cfg_q.of;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      cfg_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cfg_q <= cfg_d;
    end
  end
endmodule

module hpm_counter_bank #(
  parameter int NumCounters  = 6,
  parameter int CounterWidth = 64,
  parameter int NumEvents    = 48,
  parameter int EventIdWidth = 8,
  parameter int IncWidth     = 4,
  parameter int XLEN         = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          debug_mode_i,
  input  logic [1:0]                    priv_lvl_i,
  input  logic [31:0]                   mcountinhibit_i,
  input  logic [NumEvents*IncWidth-1:0] event_inc_i,
  input  logic [11:0]                   addr_i,
  input  logic                          we_i,
  input  logic [XLEN-1:0]               data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          access_err_o,
  output logic                          lcofi_o
);
  // architectural window is 29 slots (indices 3..31) per region
  localparam int MapSpan = 29;

  logic [NumEvents-1:0][IncWidth-1:0] lanes;
  logic [11:0]                        off_cnt, off_cnth, off_evt, off_evth;
  logic                               in_cnt, in_cnth, in_evt, in_evth;
  logic                               in_any, is_hi, is_cnt, idx_ok, mapped, wr;
  logic [4:0]                         idx;
  logic [63:0]                        wdata64, rd64;
  logic [NumCounters-1:0][63:0]       cnt_view, evt_view;
  logic [NumCounters-1:0]             of_vec;
  logic                               unused_inh;

  assign lanes      = event_inc_i;
  assign wdata64    = 64'(data_i);
  assign unused_inh = ^mcountinhibit_i;

  assign off_cnt  = addr_i - 12'hB03;
  assign off_cnth = addr_i - 12'hB83;
  assign off_evt  = addr_i - 12'h323;
  assign off_evth = addr_i - 12'h723;
  assign in_cnt   = off_cnt  < 12'(MapSpan);
  assign in_cnth  = off_cnth < 12'(MapSpan);
  assign in_evt   = off_evt  < 12'(MapSpan);
  assign in_evth  = off_evth < 12'(MapSpan);

  assign in_any = in_cnt | in_cnth | in_evt | in_evth;
  assign is_hi  = in_cnth | in_evth;
  assign is_cnt = in_cnt | in_cnth;
  assign idx    = in_cnt  ? off_cnt[4:0]  :
                  in_cnth ? off_cnth[4:0] :
                  in_evt  ? off_evt[4:0]  : off_evth[4:0];
  assign idx_ok = 32'(idx) < 32'(NumCounters);
  assign mapped = in_any && idx_ok && (!is_hi || XLEN == 32);
  assign wr     = we_i && mapped;

  assign access_err_o = in_any ? !mapped : we_i;

  for (genvar i = 0; i < NumCounters; i++) begin : g_ctr
    logic hit;
    assign hit = wr && (idx == 5'(i));
    hpm_counter_slice #(
      .CounterWidth(CounterWidth), .NumEvents(NumEvents), .EventIdWidth(EventIdWidth),
      .IncWidth(IncWidth), .XLEN(XLEN)
    ) u_slice (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cnt_en_i    (!debug_mode_i && !mcountinhibit_i[i+3]),
      .priv_lvl_i  (priv_lvl_i),
      .lanes_i     (lanes),
      .cnt_wr_lo_i (hit && in_cnt),
      .cnt_wr_hi_i (hit && in_cnth),
      .evt_wr_lo_i (hit && in_evt),
      .evt_wr_hi_i (hit && in_evth),
      .wdata_i     (wdata64),
      .cnt_view_o  (cnt_view[i]),
      .evt_view_o  (evt_view[i]),
      .of_o        (of_vec[i])
    );
  end

  always_comb begin
    rd64 = '0;
    for (int i = 0; i < NumCounters; i++)
      if (idx == 5'(i)) rd64 = is_cnt ? cnt_view[i] : evt_view[i];
    data_o = '0;
    if (mapped) data_o = is_hi ? XLEN'(rd64[63:32]) : rd64[XLEN-1:0];
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lcofi_o <= 1'b0;
    else         lcofi_o <= |of_vec;
  end
`else
  logic unused_of;
  assign unused_of = |of_vec;
  assign lcofi_o   = 1'b0;
`endif
endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank at default parameters; OF expectations
// follow HPM_OVERFLOW_IRQ_EN.
module tb_hpm_counter_bank;
  localparam int N = 6, CW = 64, NE = 48, EIW = 8, IW = 4, XL = 64;
`ifdef HPM_OVERFLOW_IRQ_EN
  localparam logic OF_EN = 1'b1;
`else
  localparam logic OF_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni, debug_mode_i, we_i, access_err_o, lcofi_o;
  logic [1:0]        priv_lvl_i;
  logic [31:0]       mcountinhibit_i;
  logic [NE*IW-1:0]  event_inc_i;
  logic [11:0]       addr_i;
  logic [XL-1:0]     data_i, data_o;
  int                checks = 0, passes = 0;

  always #5 clk_i = ~clk_i;

  hpm_counter_bank #(
    .NumCounters(N), .CounterWidth(CW), .NumEvents(NE), .EventIdWidth(EIW),
    .IncWidth(IW), .XLEN(XL)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug_mode_i),
    .priv_lvl_i(priv_lvl_i), .mcountinhibit_i(mcountinhibit_i),
    .event_inc_i(event_inc_i), .addr_i(addr_i), .we_i(we_i), .data_i(data_i),
    .data_o(data_o), .access_err_o(access_err_o), .lcofi_o(lcofi_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d);
    addr_i = a; data_i = d; we_i = 1'b1;
    tick();
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string tag);
    addr_i = a; we_i = 1'b0; #1;
    chk(tag, data_o, exp);
  endtask

  task automatic lane(input int e, input logic [3:0] v);
    event_inc_i[e*IW +: IW] = v;
  endtask

  initial begin
    rst_ni = 1'b0; debug_mode_i = 1'b0; we_i = 1'b0; priv_lvl_i = 2'd3;
    mcountinhibit_i = '0; event_inc_i = '0; addr_i = '0; data_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // reset state
    for (int i = 0; i < N; i++) begin
      rd(12'hB03 + 12'(i), 64'd0, $sformatf("rst_cnt%0d", i));
      rd(12'h323 + 12'(i), 64'd0, $sformatf("rst_evt%0d", i));
    end
    chk("rst_lcofi", 64'(lcofi_o), 64'd0);

    // basic counting on lane 5
    wr(12'h323, 64'd5);
    lane(5, 4'd3);
    repeat (10) tick();
    lane(5, 4'd0);
    rd(12'hB03, 64'd30, "count30");
    lane(5, 4'hF);
    tick();
    lane(5, 4'd0);
    rd(12'hB03, 64'd45, "count45");

    // wrap and overflow interrupt
    wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFE);
    lane(5, 4'd3);
    tick();
    lane(5, 4'd0);
    rd(12'hB03, 64'd1, "wrap_val");
    rd(12'h323, {OF_EN, 63'd5}, "wrap_of");
    chk("lcofi_edge0", 64'(lcofi_o), 64'd0);
    tick();
    chk("lcofi_edge1", 64'(lcofi_o), 64'(OF_EN));
    wr(12'h323, 64'd5);
    chk("lcofi_clr0", 64'(lcofi_o), 64'(OF_EN));
    tick();
    chk("lcofi_clr1", 64'(lcofi_o), 64'd0);
    rd(12'h323, 64'd5, "of_cleared");

    // MINH filter: only the S-mode quarters count
    wr(12'hB03, 64'd0);
    wr(12'h323, 64'h4000_0000_0000_0005);
    rd(12'h323, 64'h4000_0000_0000_0005, "minh_rb");
    lane(5, 4'd1);
    for (int c = 0; c < 16; c++) begin
      priv_lvl_i = ((c / 4) % 2 != 0) ? 2'd1 : 2'd3;
      tick();
    end
    lane(5, 4'd0);
    priv_lvl_i = 2'd3;
    rd(12'hB03, 64'd8, "minh_count");
    wr(12'h323, 64'd5);

    // counter write beats same-cycle increment; inhibit and debug freeze
    lane(5, 4'd2);
    addr_i = 12'hB03; data_i = 64'd100; we_i = 1'b1;
    tick();
    we_i = 1'b0;
    rd(12'hB03, 64'd100, "wr_wins");
    tick();
    rd(12'hB03, 64'd102, "post_wr_inc");
    mcountinhibit_i[3] = 1'b1;
    repeat (3) tick();
    rd(12'hB03, 64'd102, "inhibit_frz");
    mcountinhibit_i[3] = 1'b0;
    debug_mode_i = 1'b1;
    repeat (3) tick();
    rd(12'hB03, 64'd102, "debug_frz");
    lane(5, 4'd0);
    debug_mode_i = 1'b0;

    // access errors
    addr_i = 12'hB83; data_i = 64'h55; we_i = 1'b1; #1;
    chk("err_hi_wr", 64'(access_err_o), 64'd1);
    tick();
    we_i = 1'b0;
    rd(12'hB03, 64'd102, "hi_wr_noeff");
    addr_i = 12'hB83; #1;
    chk("err_hi_rd", 64'(access_err_o), 64'd1);
    chk("hi_rd_data", data_o, 64'd0);
    addr_i = 12'h329; data_i = 64'd9; we_i = 1'b1; #1;
    chk("err_idx_wr", 64'(access_err_o), 64'd1);
    tick();
    we_i = 1'b0; #1;
    chk("err_idx_rd", 64'(access_err_o), 64'd1);
    rd(12'h328, 64'd0, "last_evt_ok");
    chk("last_evt_err", 64'(access_err_o), 64'd0);
    addr_i = 12'h000; #1;
    chk("unmap_rd_err", 64'(access_err_o), 64'd0);
    chk("unmap_rd_data", data_o, 64'd0);
    we_i = 1'b1; #1;
    chk("unmap_wr_err", 64'(access_err_o), 64'd1);
    we_i = 1'b0;

    // last counter, and out-of-range select counts nothing
    wr(12'h328, 64'd7);
    wr(12'h324, 64'd48);
    rd(12'h324, 64'd48, "sel48_rb");
    lane(7, 4'd2);
    lane(5, 4'd1);
    repeat (2) tick();
    lane(7, 4'd0);
    lane(5, 4'd0);
    rd(12'hB08, 64'd4, "last_cnt");
    rd(12'hB04, 64'd0, "sel_oob");
    rd(12'hB05, 64'd0, "sel_zero");
    rd(12'hB03, 64'd104, "cnt0_again");

    // event write coinciding with hardware overflow
    wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    lane(5, 4'd1);
    addr_i = 12'h323; data_i = 64'd5; we_i = 1'b1;
    tick();
    we_i = 1'b0;
    lane(5, 4'd0);
    rd(12'hB03, 64'd0, "evtwr_inc");
    rd(12'h323, {OF_EN, 63'd5}, "evtwr_of");

    // asynchronous reset mid-count
    lane(5, 4'd1);
    tick();
    #2 rst_ni = 1'b0;
    rd(12'hB03, 64'd0, "arst_cnt");
    rd(12'h323, 64'd0, "arst_evt");
    chk("arst_lcofi", 64'(lcofi_o), 64'd0);
    lane(5, 4'd0);
    tick();
    rst_ni = 1'b1;
    rd(12'hB08, 64'd0, "arst_cnt5");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
